// File: rtl/concat_block_builder.sv
// Header/nonce concatenator: captures one header and one nonce through valid/ready
// handshakes, then emits one or more assembled blocks with an incrementing nonce.
module concat_block_builder #(
   parameter int HDR_BYTES   = 12,
   parameter int NONCE_BYTES = 4,
   parameter int CNT_W       = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           hdr_valid,
   output logic                           hdr_ready,
   input  logic [HDR_BYTES*8-1:0]         hdr_data,
   input  logic                           nonce_valid,
   output logic                           nonce_ready,
   input  logic [NONCE_BYTES*8-1:0]       nonce_data,
   input  logic [CNT_W-1:0]               sweep_count,
   input  logic                           nonce_first,
   output logic                           blk_valid,
   input  logic                           blk_ready,
   output logic [(HDR_BYTES+NONCE_BYTES)*8-1:0] blk_data,
   output logic                           blk_last,
   output logic                           busy
);

   localparam int BLK_BYTES = HDR_BYTES + NONCE_BYTES;
   localparam int HDR_W     = HDR_BYTES * 8;
   localparam int NONCE_W   = NONCE_BYTES * 8;
   localparam int BLK_W     = BLK_BYTES * 8;

   localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [NONCE_W-1:0] NONCE_ZERO = {NONCE_W{1'b0}};
   localparam logic [NONCE_W-1:0] NONCE_ONE  = {{(NONCE_W-1){1'b0}}, 1'b1};
   localparam logic [HDR_W-1:0]   HDR_ZERO   = {HDR_W{1'b0}};
   localparam logic [BLK_W-1:0]   BLK_ZERO   = {BLK_W{1'b0}};

   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_EMIT    = 1'b1
   } state_t;

   // The operand listed first lands in the MSBs of the block.
   function automatic logic [BLK_W-1:0] assemble_block(
      input logic [HDR_W-1:0]   hdr,
      input logic [NONCE_W-1:0] nonce,
      input logic               nonce_high
   );
      logic [BLK_W-1:0] blk;
      if (nonce_high) begin
         blk = {nonce, hdr};
      end else begin
         blk = {hdr, nonce};
      end
      return blk;
   endfunction

   state_t               state_r,       state_s;
   logic                 hdr_full_r,    hdr_full_s;
   logic                 nonce_full_r,  nonce_full_s;
   logic [HDR_W-1:0]     hdr_r,         hdr_s;
   logic                 nonce_first_r, nonce_first_s;
   logic [NONCE_W-1:0]   cur_nonce_r,   cur_nonce_s;
   logic [CNT_W-1:0]     remaining_r,   remaining_s;
   logic                 blk_valid_r,   blk_valid_s;
   logic [BLK_W-1:0]     blk_data_r,    blk_data_s;
   logic                 blk_last_r,    blk_last_s;
   logic                 busy_r,        busy_s;
   logic                 hdr_acc_s;
   logic                 nonce_acc_s;

   assign hdr_ready   = enable & ~hdr_full_r;
   assign nonce_ready = enable & ~nonce_full_r;
   assign blk_valid   = blk_valid_r;
   assign blk_data    = blk_data_r;
   assign blk_last    = blk_last_r;
   assign busy        = busy_r;

   // Next-state, hold-register and registered-output computation.
   always_comb begin
      hdr_acc_s     = hdr_valid & enable & ~hdr_full_r;
      nonce_acc_s   = nonce_valid & enable & ~nonce_full_r;
      state_s       = state_r;
      hdr_full_s    = hdr_full_r;
      nonce_full_s  = nonce_full_r;
      hdr_s         = hdr_r;
      nonce_first_s = nonce_first_r;
      cur_nonce_s   = cur_nonce_r;
      remaining_s   = remaining_r;
      blk_valid_s   = blk_valid_r;
      blk_data_s    = blk_data_r;
      blk_last_s    = blk_last_r;

      if (!enable) begin
         // Flush: drops any held inputs and any unacknowledged block.
         state_s      = ST_COLLECT;
         hdr_full_s   = 1'b0;
         nonce_full_s = 1'b0;
         cur_nonce_s  = NONCE_ZERO;
         remaining_s  = CNT_ZERO;
         blk_valid_s  = 1'b0;
         blk_data_s   = BLK_ZERO;
         blk_last_s   = 1'b0;
      end else begin
         case (state_r)
            ST_COLLECT: begin
               if (hdr_acc_s) begin
                  hdr_full_s    = 1'b1;
                  hdr_s         = hdr_data;
                  nonce_first_s = nonce_first;
               end else begin
                  hdr_full_s    = hdr_full_r;
               end
               if (nonce_acc_s) begin
                  nonce_full_s = 1'b1;
                  cur_nonce_s  = nonce_data;
                  remaining_s  = (sweep_count == CNT_ZERO) ? CNT_ONE : sweep_count;
               end else begin
                  nonce_full_s = nonce_full_r;
               end
               // Present the first block on the edge that completes the pair.
               if (hdr_full_s && nonce_full_s) begin
                  state_s     = ST_EMIT;
                  blk_valid_s = 1'b1;
                  blk_data_s  = assemble_block(hdr_s, cur_nonce_s, nonce_first_s);
                  blk_last_s  = (remaining_s == CNT_ONE);
               end else begin
                  blk_valid_s = 1'b0;
                  blk_data_s  = BLK_ZERO;
                  blk_last_s  = 1'b0;
               end
            end
            ST_EMIT: begin
               if (blk_valid_r && blk_ready) begin
                  if (remaining_r == CNT_ONE) begin
                     state_s      = ST_COLLECT;
                     hdr_full_s   = 1'b0;
                     nonce_full_s = 1'b0;
                     remaining_s  = CNT_ZERO;
                     blk_valid_s  = 1'b0;
                     blk_data_s   = BLK_ZERO;
                     blk_last_s   = 1'b0;
                  end else begin
                     cur_nonce_s = cur_nonce_r + NONCE_ONE;
                     remaining_s = remaining_r - CNT_ONE;
                     blk_data_s  = assemble_block(hdr_r, cur_nonce_s, nonce_first_r);
                     blk_last_s  = (remaining_s == CNT_ONE);
                  end
               end else begin
                  blk_data_s = blk_data_r;
                  blk_last_s = blk_last_r;
               end
            end
            default: begin
               state_s      = ST_COLLECT;
               hdr_full_s   = 1'b0;
               nonce_full_s = 1'b0;
               blk_valid_s  = 1'b0;
               blk_data_s   = BLK_ZERO;
               blk_last_s   = 1'b0;
            end
         endcase
      end

      busy_s = hdr_full_s | nonce_full_s | (state_s == ST_EMIT);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r       <= ST_COLLECT;
         hdr_full_r    <= 1'b0;
         nonce_full_r  <= 1'b0;
         hdr_r         <= HDR_ZERO;
         nonce_first_r <= 1'b0;
         cur_nonce_r   <= NONCE_ZERO;
         remaining_r   <= CNT_ZERO;
         blk_valid_r   <= 1'b0;
         blk_data_r    <= BLK_ZERO;
         blk_last_r    <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         state_r       <= state_s;
         hdr_full_r    <= hdr_full_s;
         nonce_full_r  <= nonce_full_s;
         hdr_r         <= hdr_s;
         nonce_first_r <= nonce_first_s;
         cur_nonce_r   <= cur_nonce_s;
         remaining_r   <= remaining_s;
         blk_valid_r   <= blk_valid_s;
         blk_data_r    <= blk_data_s;
         blk_last_r    <= blk_last_s;
         busy_r        <= busy_s;
      end
   end

endmodule

// File: tb/tb_concat_block_builder.sv
// Directed self-checking bench for concat_block_builder (default 12/4/16 configuration).
module tb_concat_block_builder;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          hdr_valid;
   logic          hdr_ready;
   logic [95:0]   hdr_data;
   logic          nonce_valid;
   logic          nonce_ready;
   logic [31:0]   nonce_data;
   logic [15:0]   sweep_count;
   logic          nonce_first;
   logic          blk_valid;
   logic          blk_ready;
   logic [127:0]  blk_data;
   logic          blk_last;
   logic          busy;

   int vec_cnt = 0;
   int err_cnt = 0;

   localparam logic [95:0] HDR_A = 96'h0B0A_0908_0706_0504_0302_0100;
   localparam logic [95:0] HDR_B = 96'h1122_3344_5566_7788_99AA_BBCC;

   concat_block_builder #(.HDR_BYTES(12), .NONCE_BYTES(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_data(hdr_data),
      .nonce_valid(nonce_valid), .nonce_ready(nonce_ready), .nonce_data(nonce_data),
      .sweep_count(sweep_count), .nonce_first(nonce_first),
      .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
      .blk_last(blk_last), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer header and nonce together for one accepting edge.
   task automatic load_pair(input logic [95:0] h, input logic [31:0] n,
                            input logic [15:0] sc, input logic nf);
      hdr_data = h; nonce_data = n; sweep_count = sc; nonce_first = nf;
      hdr_valid = 1'b1; nonce_valid = 1'b1;
      tick();
      hdr_valid = 1'b0; nonce_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b1; hdr_valid = 1'b0; nonce_valid = 1'b0;
      hdr_data = '0; nonce_data = '0; sweep_count = '0; nonce_first = 1'b0;
      blk_ready = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      vec_cnt++;
      if ({blk_valid, blk_last, busy} !== 3'b000) begin
         err_cnt++; $display("FAIL reset_flags: got v/l/b=%b%b%b expected 000", blk_valid, blk_last, busy);
      end
      vec_cnt++;
      if (blk_data !== 128'h0) begin
         err_cnt++; $display("FAIL reset_data: got %h expected 0", blk_data);
      end
      vec_cnt++;
      if ({hdr_ready, nonce_ready} !== 2'b11) begin
         err_cnt++; $display("FAIL reset_ready: got %b expected 11", {hdr_ready, nonce_ready});
      end
   endtask

   task automatic test_same_cycle();
      blk_ready = 1'b1;
      load_pair(HDR_A, 32'hDEADBEEF, 16'd0, 1'b1);
      vec_cnt++;
      if ({blk_valid, blk_last, busy} !== 3'b111) begin
         err_cnt++; $display("FAIL same_flags: got v/l/b=%b%b%b expected 111", blk_valid, blk_last, busy);
      end
      vec_cnt++;
      if (blk_data !== {32'hDEADBEEF, HDR_A}) begin
         err_cnt++; $display("FAIL same_data: got %h expected %h", blk_data, {32'hDEADBEEF, HDR_A});
      end
      vec_cnt++;
      if ({hdr_ready, nonce_ready} !== 2'b00) begin
         err_cnt++; $display("FAIL same_ready_emit: got %b expected 00", {hdr_ready, nonce_ready});
      end
      tick();
      vec_cnt++;
      if ({blk_valid, busy, hdr_ready, nonce_ready} !== 4'b0011) begin
         err_cnt++; $display("FAIL same_after: got v/b/hr/nr=%b%b%b%b expected 0011",
                             blk_valid, busy, hdr_ready, nonce_ready);
      end
      vec_cnt++;
      if (blk_data !== 128'h0) begin
         err_cnt++; $display("FAIL same_data_clear: got %h expected 0", blk_data);
      end
   endtask

   task automatic test_header_first();
      blk_ready = 1'b0;
      hdr_data = HDR_B; nonce_first = 1'b0; hdr_valid = 1'b1;
      tick();
      hdr_valid = 1'b0;
      nonce_first = 1'b1;   // must be ignored: order was latched with the header
      for (int i = 0; i < 4; i++) begin
         vec_cnt++;
         if ({hdr_ready, nonce_ready, blk_valid, busy} !== 4'b0101) begin
            err_cnt++; $display("FAIL hfirst_wait%0d: got hr/nr/v/b=%b%b%b%b expected 0101",
                                i, hdr_ready, nonce_ready, blk_valid, busy);
         end
         tick();
      end
      nonce_data = 32'h12345678; sweep_count = 16'd1; nonce_valid = 1'b1;
      tick();
      nonce_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vec_cnt++;
         if (blk_data !== {HDR_B, 32'h12345678} || blk_valid !== 1'b1 || blk_last !== 1'b1) begin
            err_cnt++; $display("FAIL hfirst_block%0d: got v=%b l=%b %h expected v=1 l=1 %h",
                                i, blk_valid, blk_last, blk_data, {HDR_B, 32'h12345678});
         end
         vec_cnt++;
         if (hdr_ready !== 1'b0) begin
            err_cnt++; $display("FAIL hfirst_hdr_ready%0d: got %b expected 0", i, hdr_ready);
         end
         tick();
      end
      blk_ready = 1'b1;
      tick();
      vec_cnt++;
      if ({blk_valid, hdr_ready} !== 2'b01) begin
         err_cnt++; $display("FAIL hfirst_done: got v/hr=%b%b expected 01", blk_valid, hdr_ready);
      end
   endtask

   task automatic test_sweep();
      logic [31:0] exp_n;
      blk_ready = 1'b1;
      exp_n = 32'hFFFFFFFE;
      load_pair(HDR_A, 32'hFFFFFFFE, 16'd4, 1'b0);
      for (int i = 0; i < 4; i++) begin
         vec_cnt++;
         if (blk_valid !== 1'b1 || blk_data !== {HDR_A, exp_n} || blk_last !== (i == 3)) begin
            err_cnt++; $display("FAIL sweep_blk%0d: got v=%b l=%b %h expected v=1 l=%0d %h",
                                i, blk_valid, blk_last, blk_data, (i == 3), {HDR_A, exp_n});
         end
         exp_n = exp_n + 32'd1;
         tick();
      end
      vec_cnt++;
      if ({blk_valid, busy} !== 2'b00) begin
         err_cnt++; $display("FAIL sweep_end: got v/b=%b%b expected 00", blk_valid, busy);
      end
   endtask

   task automatic test_back_pressure();
      logic [5:0]  pat;
      logic [31:0] exp_n;
      int          taken;
      pat = 6'b101001;   // blk_ready sequence 1,0,0,1,0,1 from bit 0
      taken = 0;
      exp_n = 32'h00000100;
      blk_ready = 1'b0;
      load_pair(HDR_B, 32'h00000100, 16'd3, 1'b1);
      for (int k = 0; k < 6; k++) begin
         blk_ready = pat[k];
         vec_cnt++;
         if (blk_valid !== 1'b1 || blk_data !== {exp_n, HDR_B} || blk_last !== (taken == 2)) begin
            err_cnt++; $display("FAIL bp_step%0d: got v=%b l=%b %h expected v=1 l=%0d %h",
                                k, blk_valid, blk_last, blk_data, (taken == 2), {exp_n, HDR_B});
         end
         tick();
         if (pat[k]) begin
            taken++;
            exp_n = exp_n + 32'd1;
         end
      end
      vec_cnt++;
      if ({blk_valid, busy} !== 2'b00) begin
         err_cnt++; $display("FAIL bp_end: got v/b=%b%b expected 00", blk_valid, busy);
      end
   endtask

   task automatic test_flush();
      blk_ready = 1'b1;
      load_pair(HDR_A, 32'h00000010, 16'd5, 1'b0);
      tick();
      vec_cnt++;
      if (blk_data !== {HDR_A, 32'h00000011} || blk_valid !== 1'b1) begin
         err_cnt++; $display("FAIL flush_blk2: got v=%b %h expected v=1 %h",
                             blk_valid, blk_data, {HDR_A, 32'h00000011});
      end
      enable = 1'b0;
      #1;
      vec_cnt++;
      if ({hdr_ready, nonce_ready} !== 2'b00) begin
         err_cnt++; $display("FAIL flush_ready_comb: got %b expected 00", {hdr_ready, nonce_ready});
      end
      tick();
      vec_cnt++;
      if ({blk_valid, blk_last, busy, hdr_ready, nonce_ready} !== 5'b00000 || blk_data !== 128'h0) begin
         err_cnt++; $display("FAIL flush_after: got v/l/b/hr/nr=%b%b%b%b%b %h expected 00000 0",
                             blk_valid, blk_last, busy, hdr_ready, nonce_ready, blk_data);
      end
      enable = 1'b1;
      load_pair(HDR_B, 32'h00000A00, 16'd2, 1'b0);
      vec_cnt++;
      if (blk_data !== {HDR_B, 32'h00000A00} || blk_valid !== 1'b1 || blk_last !== 1'b0) begin
         err_cnt++; $display("FAIL flush_new0: got v=%b l=%b %h expected v=1 l=0 %h",
                             blk_valid, blk_last, blk_data, {HDR_B, 32'h00000A00});
      end
      tick();
      vec_cnt++;
      if (blk_data !== {HDR_B, 32'h00000A01} || blk_valid !== 1'b1 || blk_last !== 1'b1) begin
         err_cnt++; $display("FAIL flush_new1: got v=%b l=%b %h expected v=1 l=1 %h",
                             blk_valid, blk_last, blk_data, {HDR_B, 32'h00000A01});
      end
      tick();
      vec_cnt++;
      if (blk_valid !== 1'b0) begin
         err_cnt++; $display("FAIL flush_new_end: got v=%b expected 0", blk_valid);
      end
   endtask

   task automatic test_reset_mid();
      blk_ready = 1'b0;
      load_pair(HDR_A, 32'h00000042, 16'd3, 1'b1);
      vec_cnt++;
      if (blk_valid !== 1'b1) begin
         err_cnt++; $display("FAIL rmid_emit: got v=%b expected 1", blk_valid);
      end
      reset = 1'b0;
      tick();
      vec_cnt++;
      if ({blk_valid, blk_last, busy} !== 3'b000 || blk_data !== 128'h0) begin
         err_cnt++; $display("FAIL rmid_reset: got v/l/b=%b%b%b %h expected 000 0",
                             blk_valid, blk_last, busy, blk_data);
      end
      reset = 1'b1;
      blk_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vec_cnt++;
         if ({blk_valid, busy} !== 2'b00) begin
            err_cnt++; $display("FAIL rmid_idle%0d: got v/b=%b%b expected 00", i, blk_valid, busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_same_cycle();
      test_header_first();
      test_sweep();
      test_back_pressure();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete within 200000 time units");
      $fatal(1);
   end

endmodule
